// File: rtl/button_defs_pkg.sv
// Shared definitions for the button event encoder:
// key codes, event types, FSM states and one-hot decode.
package button_defs;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_ENTER = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_UP    = 4'd7;
    localparam logic [3:0] KEY_DOWN  = 4'd8;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_REPEAT  = 2'd1;
    localparam logic [1:0] EVT_RELEASE = 2'd2;

    localparam int EVT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    // Caller masks non-one-hot vectors to zero first.
    function automatic logic [3:0] onehot_to_code(input logic [8:0] v);
        logic [3:0] c;
        c = KEY_0;
        unique case (1'b1)
            v[0]:    c = KEY_0;
            v[1]:    c = KEY_1;
            v[2]:    c = KEY_2;
            v[3]:    c = KEY_3;
            v[4]:    c = KEY_ENTER;
            v[5]:    c = KEY_LEFT;
            v[6]:    c = KEY_RIGHT;
            v[7]:    c = KEY_UP;
            v[8]:    c = KEY_DOWN;
            default: c = KEY_0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Small event FIFO with registered read/write pointers.
// A push while full succeeds only when a pop frees a slot.
module button_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && o_full && !w_pop;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed to.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/button_event_encoder.sv
// Turns resolved button levels into PRESS/REPEAT/RELEASE events.
// Auto-repeat is built only with BUTTON_AUTO_REPEAT_EN defined.
module button_event_encoder #(
    parameter int HOLD_CYCLES   = 16200000,
    parameter int REPEAT_CYCLES = 5400000,
    parameter int CNT_W         = 25,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button0_in,
    input  logic       button1_in,
    input  logic       button2_in,
    input  logic       button3_in,
    input  logic       button_enter_in,
    input  logic       button_left_in,
    input  logic       button_right_in,
    input  logic       button_up_in,
    input  logic       button_down_in,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [3:0] event_code,
    output logic [1:0] event_type,
    output logic       overflow
);

    import button_defs::*;

    logic [8:0]       w_btn;
    logic             w_valid;
    logic [3:0]       w_code;
    logic             w_held_on;
    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_held_code;
    logic             w_push;
    logic [3:0]       w_push_code;
    logic [1:0]       w_push_type;
    logic [EVT_W-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             r_overflow;

    assign w_btn = {button_down_in, button_up_in, button_right_in,
                    button_left_in, button_enter_in, button3_in,
                    button2_in, button1_in, button0_in};

    assign w_valid   = $onehot(w_btn);
    assign w_code    = onehot_to_code(w_valid ? w_btn : 9'd0);
    assign w_held_on = w_valid && (w_code == r_held_code);

`ifdef BUTTON_AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold_hit;
    logic             w_rep_hit;

    assign w_hold_hit = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_rep_hit  = (r_cnt == CNT_W'(REPEAT_CYCLES - 1));

    // Hold/repeat timer: cleared on every event, saturates otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE || w_push) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ((HOLD_CYCLES + REPEAT_CYCLES + CNT_W) != 0) ||
                          (EVT_REPEAT != 2'd0);
`endif

    // State and held key registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_held_code <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_valid) r_held_code <= w_code;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) w_next = ST_HELD;
            end
            ST_HELD: begin
                if (!w_held_on) w_next = ST_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (w_hold_hit) w_next = ST_REPEATING;
`endif
            end
            ST_REPEATING: begin
                if (!w_held_on) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Event generation toward the FIFO.
    always_comb begin
        w_push      = 1'b0;
        w_push_code = r_held_code;
        w_push_type = EVT_PRESS;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_push      = 1'b1;
                    w_push_code = w_code;
                end
            end
            ST_HELD, ST_REPEATING: begin
                if (!w_held_on) begin
                    w_push      = 1'b1;
                    w_push_type = EVT_RELEASE;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if ((r_state == ST_HELD) ? w_hold_hit : w_rep_hit) begin
                    w_push      = 1'b1;
                    w_push_type = EVT_REPEAT;
                end
`endif
            end
            default: w_push = 1'b0;
        endcase
    end

    button_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  ({w_push_code, w_push_type}),
        .i_pop   (event_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    // Sticky record of any dropped event.
    always_ff @(posedge clk) begin
        if (!reset) r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    logic w_unused_full;
    assign w_unused_full = w_full;

    assign event_valid = !w_empty;
    assign event_code  = w_empty ? 4'd0 : w_head[5:2];
    assign event_type  = w_empty ? 2'd0 : w_head[1:0];
    assign overflow    = r_overflow;

endmodule

// File: doc/button_event_encoder.md
Name: button_event_encoder

Overview:
- Consumer end of the debounced, contention-resolved button bus. The upstream bus carries nine level signals, at most one high, with at least one idle cycle between presses.
- Converts held-button levels into discrete, encoded key events (PRESS, optional auto-REPEAT, RELEASE).
- Buffers events in a small FIFO behind a valid/ready handshake.
- Feeds the UI menu FSM, which then never has to edge-detect raw button levels.

Parameters:
- HOLD_CYCLES, 16200000, cycles a button must be held before the first REPEAT (~0.6 s at 27 MHz).
- REPEAT_CYCLES, 5400000, cycles between subsequent REPEATs.
- CNT_W, 25, width of the hold/repeat counter; must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- button0_in, button1_in, button2_in, button3_in, button_enter_in, button_left_in, button_right_in, button_up_in, button_down_in  in  1 each  resolved button levels.
- event_valid  out  1  FIFO head holds an event.
- event_ready  in  1  consumer accepts the head event this cycle.
- event_code  out  4  key code of the head event.
- event_type  out  2  type of the head event.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Key codes: button0..3 = 0..3, enter = 4, left = 5, right = 6, up = 7, down = 8. Codes 9–15 are unused.
- Event types: PRESS = 0, REPEAT = 1, RELEASE = 2. Value 3 is reserved and never emitted.
- Input valid: the input is valid when exactly one bit is high. Zero bits, or more than one bit (a protocol violation), are both treated as "no button".
- Reset (reset==0):
  - state = IDLE, counter = 0, held_code = 0.
  - FIFO emptied; event_valid = 0, event_code = 0, event_type = 0, overflow = 0.
- FSM IDLE:
  - On a valid one-hot input at a posedge: push {code, PRESS}, latch held_code, clear counter, go to HELD.
- FSM HELD:
  - If held_code's bit is low, or the input is no longer valid: push {held_code, RELEASE}, go to IDLE.
  - Otherwise the counter increments. When counter == HOLD_CYCLES-1, push {held_code, REPEAT}, clear counter, go to REPEATING.
- FSM REPEATING:
  - Same release rule as HELD.
  - When counter == REPEAT_CYCLES-1, push REPEAT and clear counter.
- Direct switch to a different button (no idle gap): RELEASE of the old code is pushed. The FSM returns to IDLE and PRESS of the new code is pushed on the next cycle (one cycle later).
- Latency: a button rising before posedge k makes event_valid high after posedge k (one cycle), provided the FIFO was empty.
- Handshake:
  - Head pops at a posedge where event_valid && event_ready.
  - event_code and event_type are stable while event_valid=1 and event_ready=0.
  - event_ready while empty is ignored.
- FIFO full:
  - A push while full and no pop is dropped and sets overflow, which stays set until reset.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the pushed event appears at the head the next cycle.
- Counter: saturates at 2^CNT_W-1 defensively and never wraps. Wraparound at the HOLD/REPEAT compare is impossible given the CNT_W constraint.
- Reset mid-hold: all state cleared. If the button is still held afterwards, a fresh PRESS follows on the first cycle with reset==1.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: REPEATING state and REPEAT events are present as described.
- Undefined: no REPEAT events are emitted. HELD persists until release, the counter logic is removed, and HOLD_CYCLES/REPEAT_CYCLES are ignored.

Decomposition:
- Shared package/include (button_defs) holds:
  - key code constants KEY_0..KEY_DOWN;
  - event type constants EVT_PRESS, EVT_REPEAT, EVT_RELEASE;
  - FSM state encodings;
  - one-hot-to-code function.
- One sub-module: button_event_fifo.
  - Parameterised 6-bit wide × FIFO_DEPTH.
  - Push/pop/full/empty, with registered read/write pointers.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, FIFO_DEPTH=4, event_ready=1 unless stated):
- Press up for 3 cycles, then release -> PRESS(7) valid one cycle after press, then RELEASE(7); exactly two events.
- Hold enter 20 cycles, macro defined -> PRESS(4); REPEAT(4) at hold cycle 8; further REPEATs every 4 cycles; RELEASE(4); with macro undefined, only PRESS and RELEASE.
- event_ready=0; five quick taps of button2 (10 events) -> first 4 queued intact in order, overflow=1 and stays high; after draining, order is PRESS, RELEASE, PRESS, RELEASE.
- FIFO full with event_ready=1, and a push in the same cycle -> no overflow, count stays 4.
- button1 and button3 high together -> no events; button left held, then down asserted with left dropped in the same cycle -> RELEASE(5), then PRESS(8) one cycle later.
- Reset (reset=0) asserted mid-REPEATING with button held -> event_valid=0 and overflow=0 during reset; PRESS emitted one cycle after reset returns to 1.
